cpu_top_pipeline: RTL and testbench

Multicycle 32-bit RISC core with two independent bus-master ports: an instruction-fetch (IF) port and a data-access (MEM) port. It is the processor block of the SoC and sits between the bus arbiter/memory fabric and the 8-line interrupt sources. Each instruction runs fetch → execute → optional memory access, with a req/grant/strobe/ready handshake on both ports and a single-level maskable interrupt.

---
 rtl/cpu_top_pipeline_if.sv | 22 ++
 rtl/cpu_top_pipeline.sv | 224 ++++++++++++++++++++++
 tb/tb_cpu_top_pipeline.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_top_pipeline_if.sv
// Bus port bundle used for both the instruction-fetch and data-access ports.
// Handshake: req_/grnt_ arbitration, then as_ held until rdy_ is sampled low.
interface cpu_top_pipeline_if;
    logic [31:0] rd_data;
    logic        rdy_;
    logic        grnt_;
    logic        req_;
    logic [29:0] addr;
    logic        as_;
    logic        rw;
    logic [31:0] wr_data;

    modport master (
        input  rd_data, rdy_, grnt_,
        output req_, addr, as_, rw, wr_data
    );

    modport slave (
        output rd_data, rdy_, grnt_,
        input  req_, addr, as_, rw, wr_data
    );
endinterface

// File: rtl/cpu_top_pipeline.sv
// Multicycle 32-bit core: fetch -> execute -> optional memory access, with
// separate fetch and data bus masters and a single-level maskable interrupt.
module cpu_top_pipeline (
    input  logic               clk,
    input  logic               clk_,
    input  logic               reset,
    input  logic [7:0]         cpu_irq,
    cpu_top_pipeline_if.master if_bus,
    cpu_top_pipeline_if.master mem_bus
);
    typedef enum logic [2:0] {
        IF_REQ  = 3'd0,
        IF_ACC  = 3'd1,
        EX      = 3'd2,
        MEM_REQ = 3'd3,
        MEM_ACC = 3'd4
    } state_t;

    localparam logic [5:0] OP_AND  = 6'h00, OP_ANDI = 6'h01;
    localparam logic [5:0] OP_OR   = 6'h02, OP_ORI  = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04, OP_XORI = 6'h05;
    localparam logic [5:0] OP_ADD  = 6'h06, OP_ADDI = 6'h07;
    localparam logic [5:0] OP_SUB  = 6'h08, OP_SHL  = 6'h09;
    localparam logic [5:0] OP_SHR  = 6'h0A, OP_LUI  = 6'h0B;
    localparam logic [5:0] OP_LDW  = 6'h16, OP_STW  = 6'h17;
    localparam logic [5:0] OP_BE   = 6'h1A, OP_BNE  = 6'h1B;
    localparam logic [5:0] OP_JMP  = 6'h1C, OP_CALL = 6'h1D;
    localparam logic [5:0] OP_EI   = 6'h20, OP_DI   = 6'h21;
    localparam logic [5:0] OP_RETI = 6'h22;
    localparam logic [29:0] IRQ_VECTOR = 30'h4;

    state_t      r_state;
    logic [29:0] r_pc;
    logic [29:0] r_epc;
    logic [31:0] r_ir;
    logic        r_ie;
    logic [31:0] r_gpr [32];

    logic        r_if_req_n;
    logic        r_if_as_n;
    logic [29:0] r_if_addr;
    logic        r_mem_req_n;
    logic        r_mem_as_n;
    logic        r_mem_rw;
    logic [29:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic [5:0]  w_op;
    logic [4:0]  w_ra_idx;
    logic [4:0]  w_rb_idx;
    logic [4:0]  w_rc_idx;
    logic [15:0] w_imm;
    logic [31:0] w_ra;
    logic [31:0] w_rb;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_ea;
    logic [29:0] w_pc_inc;
    logic [29:0] w_br_tgt;
    logic        w_irq_pend;

    logic        w_wr_en;
    logic [4:0]  w_wr_idx;
    logic [31:0] w_wr_val;
    logic [29:0] w_pc_next;
    logic        w_ie_next;
    logic        w_is_mem;

    // The inverted clock only feeds downstream memories, and the byte offset of
    // the effective address is not part of a word access.
    logic w_unused;
    assign w_unused = ^{clk_, w_ea[1:0]};

    assign w_op     = r_ir[31:26];
    assign w_ra_idx = r_ir[25:21];
    assign w_rb_idx = r_ir[20:16];
    assign w_rc_idx = r_ir[15:11];
    assign w_imm    = r_ir[15:0];

    assign w_ra       = (w_ra_idx == 5'd0) ? 32'h0 : r_gpr[w_ra_idx];
    assign w_rb       = (w_rb_idx == 5'd0) ? 32'h0 : r_gpr[w_rb_idx];
    assign w_sext     = {{16{w_imm[15]}}, w_imm};
    assign w_zext     = {16'h0, w_imm};
    assign w_ea       = w_ra + w_sext;
    assign w_pc_inc   = r_pc + 30'd1;
    assign w_br_tgt   = w_pc_inc + {{14{w_imm[15]}}, w_imm};
    assign w_irq_pend = |cpu_irq;

    assign if_bus.req_     = r_if_req_n;
    assign if_bus.as_      = r_if_as_n;
    assign if_bus.addr     = r_if_addr;
    assign if_bus.rw       = 1'b1;
    assign if_bus.wr_data  = 32'h0;
    assign mem_bus.req_    = r_mem_req_n;
    assign mem_bus.as_     = r_mem_as_n;
    assign mem_bus.addr    = r_mem_addr;
    assign mem_bus.rw      = r_mem_rw;
    assign mem_bus.wr_data = r_mem_wdata;

    // Execute-stage decode: register writeback, next PC and next IE.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = w_rc_idx;
        w_wr_val  = 32'h0;
        w_pc_next = w_pc_inc;
        w_ie_next = r_ie;
        w_is_mem  = 1'b0;
        case (w_op)
            OP_AND:  begin w_wr_en = 1'b1; w_wr_val = w_ra & w_rb; end
            OP_ANDI: begin w_wr_en = 1'b1; w_wr_idx = w_rb_idx; w_wr_val = w_ra & w_zext; end
            OP_OR:   begin w_wr_en = 1'b1; w_wr_val = w_ra | w_rb; end
            OP_ORI:  begin w_wr_en = 1'b1; w_wr_idx = w_rb_idx; w_wr_val = w_ra | w_zext; end
            OP_XOR:  begin w_wr_en = 1'b1; w_wr_val = w_ra ^ w_rb; end
            OP_XORI: begin w_wr_en = 1'b1; w_wr_idx = w_rb_idx; w_wr_val = w_ra ^ w_zext; end
            OP_ADD:  begin w_wr_en = 1'b1; w_wr_val = w_ra + w_rb; end
            OP_ADDI: begin w_wr_en = 1'b1; w_wr_idx = w_rb_idx; w_wr_val = w_ra + w_sext; end
            OP_SUB:  begin w_wr_en = 1'b1; w_wr_val = w_ra - w_rb; end
            OP_SHL:  begin w_wr_en = 1'b1; w_wr_val = w_ra << w_rb[4:0]; end
            OP_SHR:  begin w_wr_en = 1'b1; w_wr_val = w_ra >> w_rb[4:0]; end
            OP_LUI:  begin w_wr_en = 1'b1; w_wr_idx = w_rb_idx; w_wr_val = {w_imm, 16'h0}; end
            OP_LDW, OP_STW: w_is_mem = 1'b1;
            OP_BE:   if (w_ra == w_rb) w_pc_next = w_br_tgt;
            OP_BNE:  if (w_ra != w_rb) w_pc_next = w_br_tgt;
            OP_JMP:  w_pc_next = w_ra[31:2];
            OP_CALL: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = 5'd31;
                w_wr_val  = {w_pc_inc, 2'b00};
                w_pc_next = w_ra[31:2];
            end
            OP_EI:   w_ie_next = 1'b1;
            OP_DI:   w_ie_next = 1'b0;
            OP_RETI: begin w_pc_next = r_epc; w_ie_next = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IF_REQ;
            r_pc        <= 30'h0;
            r_epc       <= 30'h0;
            r_ir        <= 32'h0;
            r_ie        <= 1'b0;
            r_if_req_n  <= 1'b1;
            r_if_as_n   <= 1'b1;
            r_if_addr   <= 30'h0;
            r_mem_req_n <= 1'b1;
            r_mem_as_n  <= 1'b1;
            r_mem_rw    <= 1'b1;
            r_mem_addr  <= 30'h0;
            r_mem_wdata <= 32'h0;
            for (int i = 0; i < 32; i++) r_gpr[i] <= 32'h0;
        end else begin
            case (r_state)
                IF_REQ: begin
                    r_if_req_n <= 1'b0;
                    if (!if_bus.grnt_) begin
                        r_state   <= IF_ACC;
                        r_if_as_n <= 1'b0;
                        r_if_addr <= r_pc;
                    end
                end
                IF_ACC: begin
                    if (!if_bus.rdy_) begin
                        r_ir       <= if_bus.rd_data;
                        r_state    <= EX;
                        r_if_req_n <= 1'b1;
                        r_if_as_n  <= 1'b1;
                        r_if_addr  <= 30'h0;
                    end
                end
                EX: begin
                    if (w_wr_en && w_wr_idx != 5'd0) r_gpr[w_wr_idx] <= w_wr_val;
                    if (w_is_mem) begin
                        r_state     <= MEM_REQ;
                        r_mem_req_n <= 1'b0;
                    end else begin
                        r_state    <= IF_REQ;
                        r_if_req_n <= 1'b0;
                        // IE here already reflects EI/DI/RETI of this instruction.
                        if (w_ie_next && w_irq_pend) begin
                            r_epc <= w_pc_next;
                            r_pc  <= IRQ_VECTOR;
                            r_ie  <= 1'b0;
                        end else begin
                            r_pc <= w_pc_next;
                            r_ie <= w_ie_next;
                        end
                    end
                end
                MEM_REQ: begin
                    if (!mem_bus.grnt_) begin
                        r_state     <= MEM_ACC;
                        r_mem_as_n  <= 1'b0;
                        r_mem_addr  <= w_ea[31:2];
                        r_mem_rw    <= (w_op == OP_LDW);
                        r_mem_wdata <= (w_op == OP_STW) ? w_rb : 32'h0;
                    end
                end
                MEM_ACC: begin
                    if (!mem_bus.rdy_) begin
                        if (w_op == OP_LDW && w_rb_idx != 5'd0) r_gpr[w_rb_idx] <= mem_bus.rd_data;
                        r_state     <= IF_REQ;
                        r_if_req_n  <= 1'b0;
                        r_mem_req_n <= 1'b1;
                        r_mem_as_n  <= 1'b1;
                        r_mem_rw    <= 1'b1;
                        r_mem_addr  <= 30'h0;
                        r_mem_wdata <= 32'h0;
                        if (r_ie && w_irq_pend) begin
                            r_epc <= w_pc_inc;
                            r_pc  <= IRQ_VECTOR;
                            r_ie  <= 1'b0;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                default: r_state <= IF_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_top_pipeline.sv
// Directed program bench for cpu_top_pipeline: bus monitors record every
// completed fetch and data access, and the main thread compares them in order.
module tb_cpu_top_pipeline;
    logic       clk = 1'b0;
    logic       clk_;
    logic       reset;
    logic [7:0] cpu_irq;

    cpu_top_pipeline_if if_bus ();
    cpu_top_pipeline_if mem_bus ();

    cpu_top_pipeline dut (
        .clk     (clk),
        .clk_    (clk_),
        .reset   (reset),
        .cpu_irq (cpu_irq),
        .if_bus  (if_bus),
        .mem_bus (mem_bus)
    );

    always #5 clk = ~clk;
    assign clk_ = ~clk;

    localparam logic [31:0] LD_VAL = 32'hA5C3_0F96;
    localparam logic [31:0] NOP    = 32'hFC00_0000;

    logic [31:0] imem [64];
    assign if_bus.rd_data  = imem[if_bus.addr[5:0]];
    assign mem_bus.rd_data = LD_VAL;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rw;
        logic [31:0] wd;
        int          len;
    } macc_t;

    macc_t       mem_q [$];
    logic [31:0] fa_q [$];
    int          fc_q [$];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          mem_idx = 0;
    int          slow_idx = -1;
    int          mem_req_lo = 0;
    int          overlap = 0;
    bit          slow_all = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Data-port responder plus monitors for both ports.
    always @(negedge clk) begin
        if (mem_bus.as_ == 1'b0) begin
            mem_bus.rdy_ = (slow_all || (mem_idx == slow_idx && acc_cyc < 4)) ? 1'b1 : 1'b0;
            acc_cyc++;
            if (mem_bus.rdy_ == 1'b0) begin
                mem_q.push_back('{{2'b0, mem_bus.addr}, {31'h0, mem_bus.rw}, mem_bus.wr_data, acc_cyc});
                mem_idx++;
            end
        end else begin
            acc_cyc = 0;
            mem_bus.rdy_ = 1'b0;
        end
        if (if_bus.as_ == 1'b0 && if_bus.rdy_ == 1'b0) begin
            fa_q.push_back({2'b0, if_bus.addr});
            fc_q.push_back(cyc);
        end
        if (mem_bus.req_ == 1'b0) mem_req_lo++;
        if ((if_bus.as_ == 1'b0 || if_bus.req_ == 1'b0) && (mem_bus.as_ == 1'b0 || mem_bus.req_ == 1'b0))
            overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic [15:0] imm);
        return {op, ra, rb, imm};
    endfunction

    function automatic logic [31:0] er(input logic [5:0] op, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic [4:0] rc);
        return {op, ra, rb, rc, 11'h0};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        fa_q.delete();
        fc_q.delete();
        mem_q.delete();
        mem_idx    = 0;
        mem_req_lo = 0;
        reset      = 1'b1;
    endtask

    // A missing event returns an all-ones address, which no expectation uses.
    task automatic get_fetch(output logic [31:0] a, output int c);
        int n = 0;
        while (fa_q.size() == 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (fa_q.size() != 0) begin
            a = fa_q.pop_front();
            c = fc_q.pop_front();
        end else begin
            a = '1;
            c = -1;
        end
    endtask

    task automatic get_mem(output macc_t m);
        int n = 0;
        while (mem_q.size() == 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (mem_q.size() != 0) m = mem_q.pop_front();
        else m = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1};
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] exp, output int c);
        logic [31:0] a;
        get_fetch(a, c);
        chk(tag, a, exp);
    endtask

    task automatic chk_mem(input string tag, input logic [31:0] addr, input logic [31:0] rw,
                           input logic [31:0] wd, input int len);
        macc_t m;
        get_mem(m);
        chk({tag, "_addr"}, m.addr, addr);
        chk({tag, "_rw"}, m.rw, rw);
        chk({tag, "_wd"}, m.wd, wd);
        chk({tag, "_len"}, m.len, len);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int prev;
        int fc [19];
        logic [31:0] fexp;

        reset         = 1'b0;
        cpu_irq       = 8'h0;
        if_bus.grnt_  = 1'b0;
        if_bus.rdy_   = 1'b0;
        mem_bus.grnt_ = 1'b0;

        // Reset values and straight-line fetch cadence over AND r0,r0,r0.
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        do_reset();
        chk("rst_if_req", {31'h0, if_bus.req_}, 32'd1);
        chk("rst_if_as", {31'h0, if_bus.as_}, 32'd1);
        chk("rst_if_addr", {2'b0, if_bus.addr}, 32'd0);
        chk("rst_if_rw", {31'h0, if_bus.rw}, 32'd1);
        chk("rst_if_wd", if_bus.wr_data, 32'd0);
        chk("rst_mem_req", {31'h0, mem_bus.req_}, 32'd1);
        chk("rst_mem_as", {31'h0, mem_bus.as_}, 32'd1);
        chk("rst_mem_addr", {2'b0, mem_bus.addr}, 32'd0);
        chk("rst_mem_rw", {31'h0, mem_bus.rw}, 32'd1);
        chk("rst_mem_wd", mem_bus.wr_data, 32'd0);
        release_reset();
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            chk_fetch($sformatf("s1_fetch%0d", i), i, c);
            if (i > 0) chk($sformatf("s1_gap%0d", i), c - prev, 32'd3);
            prev = c;
        end
        chk("s1_mem_req_low", mem_req_lo, 32'd0);

        // ALU, load/store, branches.
        for (int i = 0; i < 64; i++) imem[i] = NOP;
        imem[0]  = ei(6'h07, 5'd0, 5'd1, 16'd5);
        imem[1]  = ei(6'h07, 5'd1, 5'd2, 16'hFFF9);
        imem[2]  = ei(6'h17, 5'd0, 5'd2, 16'h0040);
        imem[3]  = ei(6'h16, 5'd0, 5'd3, 16'h0040);
        imem[4]  = ei(6'h17, 5'd0, 5'd3, 16'h0044);
        imem[5]  = ei(6'h1A, 5'd1, 5'd0, 16'd1);
        imem[6]  = ei(6'h0B, 5'd0, 5'd4, 16'h1234);
        imem[7]  = ei(6'h03, 5'd4, 5'd4, 16'h5678);
        imem[8]  = er(6'h08, 5'd4, 5'd1, 5'd5);
        imem[9]  = er(6'h09, 5'd1, 5'd1, 5'd6);
        imem[10] = ei(6'h17, 5'd0, 5'd5, 16'h0048);
        imem[11] = ei(6'h17, 5'd0, 5'd6, 16'h004C);
        imem[12] = ei(6'h05, 5'd4, 5'd7, 16'hFFFF);
        imem[13] = ei(6'h17, 5'd0, 5'd7, 16'h0050);
        imem[14] = er(6'h06, 5'd4, 5'd2, 5'd8);
        imem[15] = ei(6'h17, 5'd0, 5'd8, 16'h0054);
        imem[16] = ei(6'h1B, 5'd1, 5'd0, 16'hFFFF);
        slow_idx = 1;
        do_reset();
        release_reset();
        for (int i = 0; i < 19; i++) begin
            fexp = (i < 17) ? i : 32'd16;
            chk_fetch($sformatf("s2_fetch%0d", i), fexp, fc[i]);
        end
        chk("s2_alu_cycles", fc[2] - fc[1], 32'd3);
        chk("s2_stw_cycles", fc[3] - fc[2], 32'd5);
        chk("s2_ldw_wait_cycles", fc[4] - fc[3], 32'd9);
        chk_mem("s2_stw_r2", 32'h10, 32'd0, 32'hFFFF_FFFE, 1);
        chk_mem("s2_ldw_r3", 32'h10, 32'd1, 32'h0, 5);
        chk_mem("s2_stw_r3", 32'h11, 32'd0, LD_VAL, 1);
        chk_mem("s2_stw_sub", 32'h12, 32'd0, 32'h1234_5673, 1);
        chk_mem("s2_stw_shl", 32'h13, 32'd0, 32'h0000_00A0, 1);
        chk_mem("s2_stw_xori", 32'h14, 32'd0, 32'h1234_A987, 1);
        chk_mem("s2_stw_add", 32'h15, 32'd0, 32'h1234_5676, 1);
        slow_idx = -1;

        // Interrupt entry, IE cleared in the handler, return to saved PC.
        for (int i = 0; i < 64; i++) imem[i] = NOP;
        imem[0] = {6'h20, 26'h0};
        imem[4] = ei(6'h07, 5'd0, 5'd9, 16'h0033);
        imem[5] = ei(6'h17, 5'd0, 5'd9, 16'h0060);
        imem[6] = {6'h22, 26'h0};
        do_reset();
        release_reset();
        chk_fetch("s3_fetch_ei", 32'd0, c);
        chk_fetch("s3_fetch_nop", 32'd1, c);
        cpu_irq = 8'h04;
        chk_fetch("s3_fetch_vector", 32'd4, c);
        chk_fetch("s3_fetch_ie_off", 32'd5, c);
        cpu_irq = 8'h00;
        chk_mem("s3_handler_stw", 32'h18, 32'd0, 32'h33, 1);
        chk_fetch("s3_fetch_reti", 32'd6, c);
        chk_fetch("s3_fetch_resume", 32'd2, c);
        chk_fetch("s3_fetch_next", 32'd3, c);

        // Reset while a data access is stalled on ready.
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        imem[0] = ei(6'h17, 5'd0, 5'd0, 16'h0008);
        slow_all = 1'b1;
        do_reset();
        release_reset();
        for (int i = 0; i < 50 && mem_bus.as_ !== 1'b0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("s4_in_mem_acc", {31'h0, mem_bus.as_}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("s4_mem_as_idle", {31'h0, mem_bus.as_}, 32'd1);
        chk("s4_mem_req_idle", {31'h0, mem_bus.req_}, 32'd1);
        chk("s4_if_req_idle", {31'h0, if_bus.req_}, 32'd1);
        slow_all = 1'b0;
        release_reset();
        chk_fetch("s4_refetch0", 32'd0, c);
        chk_mem("s4_stw_retry", 32'h2, 32'd0, 32'h0, 1);

        chk("port_overlap", overlap, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
